// File: rtl/quad_decoder_ext.sv
// quad_decoder_ext: incremental encoder front end. Synchronises and glitch-filters A/B/Z,
// decodes quadrature at x4/x2/x1 resolution, keeps a wrapping position and signed running count,
// flags illegal transitions, homes on the index pulse and reports windowed velocity.
module quad_decoder_ext #(
  parameter int unsigned PPR      = 334,
  parameter int unsigned MODE     = 4,
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned VEL_WIN  = 100000,
  parameter int unsigned VEL_W    = 16,
  localparam int unsigned POS_N   = PPR * MODE,
  localparam int unsigned POS_W   = (POS_N > 1) ? $clog2(POS_N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             qa,
  input  logic             qb,
  input  logic             qz,
  input  logic             index_en,
  input  logic             err_clr,
  output logic             ready,
  output logic             dir,
  output logic [POS_W-1:0] pos,
  output logic [CNT_W-1:0] cnt,
  output logic             err,
  output logic             index_pulse,
  output logic [VEL_W-1:0] vel,
  output logic             vel_valid
);

  localparam int unsigned FC_W  = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned IC_W  = $clog2(FILT_LEN + 2);
  localparam int unsigned WC_W  = $clog2(VEL_WIN);
  localparam int unsigned SUM_W = VEL_W + 1;

  localparam logic [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W - 1){1'b1}}};
  localparam logic [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W - 1){1'b0}}};

  // Elaboration-time parameter sanity
  if (!(MODE == 4 || MODE == 2 || MODE == 1)) begin : gen_bad_mode
    $error("quad_decoder_ext: MODE must be 4, 2 or 1");
  end
  if (FILT_LEN < 1) begin : gen_bad_filt
    $error("quad_decoder_ext: FILT_LEN must be >= 1");
  end
  if (VEL_WIN < 2) begin : gen_bad_win
    $error("quad_decoder_ext: VEL_WIN must be >= 2");
  end

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e          state;
  logic [IC_W-1:0] init_cnt;

  // Channel order in all 3-bit vectors: [0]=A, [1]=B, [2]=Z
  logic [2:0]      sync_meta;
  logic [2:0]      sync_s;
  logic [2:0]      filt;
  logic [FC_W-1:0] filt_cnt [3];

  logic [1:0]      prev_ab;
  logic            prev_z;

  logic [WC_W-1:0]  win_cnt;
  logic [VEL_W-1:0] acc;

  logic [1:0]       cur_ab;
  logic [1:0]       ab_diff;
  logic             legal_chg;
  logic             illegal_chg;
  logic             fwd;
  logic             a_rise;
  logic             a_fall;
  logic             step_en;
  logic             z_rise;
  logic [POS_W-1:0] pos_inc;
  logic [POS_W-1:0] pos_dec;
  logic [SUM_W-1:0] step_ext;
  logic [SUM_W-1:0] acc_sum;
  logic [VEL_W-1:0] acc_next;

  // Two-flop synchronisers for the asynchronous encoder inputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_meta <= '0;
      sync_s    <= '0;
    end else begin
      sync_meta <= {qz, qb, qa};
      sync_s    <= sync_meta;
    end
  end

  // Glitch filter: a new level is accepted only after holding for FILT_LEN cycles
  always_ff @(posedge clk) begin
    if (!rst) begin
      filt <= '0;
      for (int i = 0; i < 3; i++) begin
        filt_cnt[i] <= '0;
      end
    end else if (state == StInit) begin
      // Preload so the first RUN cycle sees no spurious edges
      filt <= sync_s;
      for (int i = 0; i < 3; i++) begin
        filt_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_s[i] == filt[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FC_W'(FILT_LEN - 1)) begin
          filt[i]     <= sync_s[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + FC_W'(1);
        end
      end
    end
  end

  // Transition classification and resolution-dependent step qualification
  always_comb begin
    cur_ab      = filt[1:0];
    ab_diff     = cur_ab ^ prev_ab;
    legal_chg   = (ab_diff == 2'b01) || (ab_diff == 2'b10);
    illegal_chg = (ab_diff == 2'b11);
    // Forward order 00->01->11->10: new A always equals old B inverted... i.e. pb ^ na
    fwd         = prev_ab[1] ^ cur_ab[0];
    a_rise      = cur_ab[0] & ~prev_ab[0];
    a_fall      = ~cur_ab[0] & prev_ab[0];
    z_rise      = filt[2] & ~prev_z;
    if (MODE == 4) begin
      step_en = legal_chg;
    end else if (MODE == 2) begin
      step_en = legal_chg & ab_diff[0];
    end else begin
      step_en = legal_chg & (fwd ? a_rise : a_fall);
    end
  end

  // Position wrap arithmetic
  always_comb begin
    pos_inc = (pos == POS_W'(POS_N - 1)) ? '0 : pos + POS_W'(1);
    pos_dec = (pos == '0) ? POS_W'(POS_N - 1) : pos - POS_W'(1);
  end

  // Saturating velocity accumulator, one sign bit of headroom to detect overflow
  always_comb begin
    if (!step_en) begin
      step_ext = '0;
    end else if (fwd) begin
      step_ext = SUM_W'(1);
    end else begin
      step_ext = '1;
    end
    acc_sum = {acc[VEL_W-1], acc} + step_ext;
    if (acc_sum[VEL_W] != acc_sum[VEL_W-1]) begin
      acc_next = acc_sum[VEL_W] ? VEL_MIN : VEL_MAX;
    end else begin
      acc_next = acc_sum[VEL_W-1:0];
    end
  end

  // Control FSM with registered decoder outputs, index homing and velocity window
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= StInit;
      init_cnt    <= '0;
      prev_ab     <= '0;
      prev_z      <= 1'b0;
      ready       <= 1'b0;
      dir         <= 1'b0;
      pos         <= '0;
      cnt         <= '0;
      err         <= 1'b0;
      index_pulse <= 1'b0;
      vel         <= '0;
      vel_valid   <= 1'b0;
      win_cnt     <= '0;
      acc         <= '0;
    end else begin
      index_pulse <= 1'b0;
      vel_valid   <= 1'b0;
      prev_ab     <= cur_ab;
      prev_z      <= filt[2];
      if (err_clr) begin
        err <= 1'b0;
      end
      unique case (state)
        StInit: begin
          if (init_cnt == IC_W'(FILT_LEN + 1)) begin
            state <= StRun;
            ready <= 1'b1;
          end else begin
            init_cnt <= init_cnt + IC_W'(1);
          end
        end
        StRun: begin
          // Placed after the clear so a same-cycle illegal change wins
          if (illegal_chg) begin
            err <= 1'b1;
          end
          if (step_en) begin
            dir <= fwd;
            if (fwd) begin
              cnt <= cnt + CNT_W'(1);
              pos <= pos_inc;
            end else begin
              cnt <= cnt - CNT_W'(1);
              pos <= pos_dec;
            end
          end
          // Homing overrides the step for pos only
          if (z_rise && index_en) begin
            pos         <= '0;
            index_pulse <= 1'b1;
          end
          if (win_cnt == WC_W'(VEL_WIN - 1)) begin
            vel       <= acc_next;
            vel_valid <= 1'b1;
            acc       <= '0;
            win_cnt   <= '0;
          end else begin
            acc     <= acc_next;
            win_cnt <= win_cnt + WC_W'(1);
          end
        end
        default: state <= StInit;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_decoder_ext.sv
// Bench for quad_decoder_ext: an x4/16-bit-velocity instance and an x1/4-bit-velocity instance
// share the same encoder stimulus and are compared every cycle against a reference model.
module tb_quad_decoder_ext;

  localparam int FL   = 4;
  localparam int VWIN = 1000;
  localparam int PPR  = 334;

  logic clk      = 1'b0;
  logic rst      = 1'b0;
  logic qa       = 1'b1;
  logic qb       = 1'b1;
  logic qz       = 1'b0;
  logic index_en = 1'b0;
  logic err_clr  = 1'b0;

  logic        ready_a, dir_a, err_a, ipulse_a, vv_a;
  logic [10:0] pos_a;
  logic [31:0] cnt_a;
  logic [15:0] vel_a;
  logic        ready_b, dir_b, err_b, ipulse_b, vv_b;
  logic [8:0]  pos_b;
  logic [31:0] cnt_b;
  logic [3:0]  vel_b;

  quad_decoder_ext #(
    .PPR(PPR), .MODE(4), .FILT_LEN(FL), .CNT_W(32), .VEL_WIN(VWIN), .VEL_W(16)
  ) dut_x4 (
    .clk(clk), .rst(rst), .qa(qa), .qb(qb), .qz(qz), .index_en(index_en), .err_clr(err_clr),
    .ready(ready_a), .dir(dir_a), .pos(pos_a), .cnt(cnt_a), .err(err_a),
    .index_pulse(ipulse_a), .vel(vel_a), .vel_valid(vv_a)
  );

  quad_decoder_ext #(
    .PPR(PPR), .MODE(1), .FILT_LEN(FL), .CNT_W(32), .VEL_WIN(VWIN), .VEL_W(4)
  ) dut_x1 (
    .clk(clk), .rst(rst), .qa(qa), .qb(qb), .qz(qz), .index_en(index_en), .err_clr(err_clr),
    .ready(ready_b), .dir(dir_b), .pos(pos_b), .cnt(cnt_b), .err(err_b),
    .index_pulse(ipulse_b), .vel(vel_b), .vel_valid(vv_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Gray position of each {B,A} level along the forward sequence and its inverse
  int         g2i [4] = '{0, 1, 3, 2};
  logic [1:0] i2g [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  // ---------------- reference model ----------------
  logic [2:0] m_sync1 = '0;
  logic [2:0] m_shist [FL];
  logic [2:0] m_f     = '0;
  logic [2:0] m_fold  = '0;
  bit         m_run   = 1'b0;
  bit         m_ready = 1'b0;
  int         m_init_left = 2 + FL;
  int         m_cnt [2] = '{0, 0};
  int         m_pos [2] = '{0, 0};
  int         m_acc [2] = '{0, 0};
  int         m_vel [2] = '{0, 0};
  int         m_wc  [2] = '{0, 0};
  bit         m_dir [2] = '{0, 0};
  bit         m_err [2] = '{0, 0};
  bit         m_ip  [2] = '{0, 0};
  bit         m_vv  [2] = '{0, 0};

  always @(posedge clk) begin : model_proc
    logic [2:0] fn;
    int dd, stp, mode, npos, acc, vmax;
    bit fwd, cnt_it, all_new;
    if (!rst) begin
      m_sync1 = '0;
      for (int k = 0; k < FL; k++) m_shist[k] = '0;
      m_f = '0;
      m_fold = '0;
      m_run = 1'b0;
      m_ready = 1'b0;
      m_init_left = 2 + FL;
      for (int d = 0; d < 2; d++) begin
        m_cnt[d] = 0; m_pos[d] = 0; m_acc[d] = 0; m_vel[d] = 0; m_wc[d] = 0;
        m_dir[d] = 0; m_err[d] = 0; m_ip[d] = 0; m_vv[d] = 0;
      end
    end else begin
      // Filtered level: follows the synced input in init; in run flips once the synced
      // input has shown the opposite level on each of the last FL samples
      if (!m_run) begin
        fn = m_shist[0];
      end else begin
        fn = m_f;
        for (int i = 0; i < 3; i++) begin
          all_new = 1'b1;
          for (int k = 0; k < FL; k++) if (m_shist[k][i] == m_f[i]) all_new = 1'b0;
          if (all_new) fn[i] = ~m_f[i];
        end
      end
      for (int d = 0; d < 2; d++) begin
        m_ip[d] = 1'b0;
        m_vv[d] = 1'b0;
        if (err_clr) m_err[d] = 1'b0;
        if (m_run) begin
          mode = (d == 0) ? 4 : 1;
          npos = PPR * mode;
          vmax = (d == 0) ? 32767 : 7;
          dd   = (g2i[m_f[1:0]] - g2i[m_fold[1:0]] + 4) % 4;
          stp  = 0;
          if (dd == 2) m_err[d] = 1'b1;
          if (dd == 1 || dd == 3) begin
            fwd = (dd == 1);
            if (mode == 4) cnt_it = 1'b1;
            else if (mode == 2) cnt_it = (m_f[0] != m_fold[0]);
            else cnt_it = fwd ? (m_f[0] && !m_fold[0]) : (!m_f[0] && m_fold[0]);
            if (cnt_it) stp = fwd ? 1 : -1;
          end
          if (stp != 0) begin
            m_dir[d] = (stp > 0);
            m_cnt[d] = m_cnt[d] + stp;
            m_pos[d] = (m_pos[d] + stp + npos) % npos;
          end
          if (m_f[2] && !m_fold[2] && index_en) begin
            m_pos[d] = 0;
            m_ip[d]  = 1'b1;
          end
          acc = m_acc[d] + stp;
          if (acc > vmax) acc = vmax;
          if (acc < -vmax - 1) acc = -vmax - 1;
          if (m_wc[d] == VWIN - 1) begin
            m_vel[d] = acc; m_vv[d] = 1'b1; m_acc[d] = 0; m_wc[d] = 0;
          end else begin
            m_acc[d] = acc; m_wc[d] = m_wc[d] + 1;
          end
        end
      end
      m_fold = m_f;
      m_f = fn;
      for (int k = FL - 1; k > 0; k--) m_shist[k] = m_shist[k-1];
      m_shist[0] = m_sync1;
      m_sync1 = {qz, qb, qa};
      if (!m_run) begin
        m_init_left = m_init_left - 1;
        if (m_init_left == 0) begin
          m_run = 1'b1;
          m_ready = 1'b1;
        end
      end
    end
  end

  function automatic logic [63:0] model_word(input int d);
    logic [10:0] p;
    logic [15:0] v;
    logic [31:0] c;
    p = 11'(m_pos[d]);
    c = 32'(m_cnt[d]);
    v = (d == 0) ? 16'(m_vel[d]) : {12'h000, 4'(m_vel[d])};
    return {m_ready, m_dir[d], m_err[d], m_ip[d], m_vv[d], p, v, c};
  endfunction

  // Cycle-by-cycle comparison, away from the active edge
  always @(negedge clk) begin
    check_val("x4_outputs", {ready_a, dir_a, err_a, ipulse_a, vv_a, pos_a, vel_a, cnt_a},
              model_word(0));
    check_val("x1_outputs", {ready_b, dir_b, err_b, ipulse_b, vv_b, 2'b00, pos_b, 12'h000,
              vel_b, cnt_b}, model_word(1));
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step(input bit fwd, input int hold);
    int g;
    g = g2i[{qb, qa}];
    g = fwd ? (g + 1) % 4 : (g + 3) % 4;
    {qb, qa} = i2g[g];
    tick(hold);
  endtask

  task automatic wait_vel_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1500 && !seen; i++) begin
      tick(1);
      if (vv_a) seen = 1'b1;
    end
    check_val("vel_valid_seen", 64'(seen), 64'd1);
  endtask

  initial begin : stim
    int lat, np, op, hold, g;
    logic [31:0] cnt_old;
    logic [10:0] pos_old;

    // Reset and init with A=B=1
    tick(3);
    rst = 1'b1;
    tick(2 + FL - 1);
    check_val("init_not_ready", 64'(ready_a), 64'd0);
    tick(1);
    check_val("init_ready", 64'(ready_a), 64'd1);
    check_val("init_cnt", 64'(cnt_a), 64'd0);
    check_val("init_pos", 64'(pos_a), 64'd0);
    check_val("init_err", 64'(err_a), 64'd0);

    // One reverse step from zero wraps position
    step(1'b0, 8);
    check_val("rev_wrap_pos", 64'(pos_a), 64'd1335);
    check_val("rev_wrap_cnt", 64'(cnt_a), 64'hffff_ffff);
    check_val("rev_wrap_dir", 64'(dir_a), 64'd0);
    step(1'b1, 8);

    // Ten forward Gray cycles, first step timed
    g = g2i[{qb, qa}];
    {qb, qa} = i2g[(g + 1) % 4];
    pos_old = pos_a;
    lat = 0;
    while (pos_a == pos_old && lat < 20) begin
      tick(1);
      lat++;
    end
    check_val("step_latency", 64'(lat), 64'd7);
    tick(2);
    for (int i = 0; i < 39; i++) step(1'b1, 8);
    check_val("fwd_cnt", 64'(cnt_a), 64'd40);
    check_val("fwd_pos", 64'(pos_a), 64'd40);
    check_val("fwd_dir", 64'(dir_a), 64'd1);
    check_val("x1_fwd_cnt", 64'(cnt_b), 64'd10);

    // Short glitch on A, then an illegal double change, then clear
    cnt_old = cnt_a;
    qa = ~qa;
    tick(3);
    qa = ~qa;
    tick(10);
    check_val("glitch_cnt", 64'(cnt_a), 64'(cnt_old));
    {qb, qa} = ~{qb, qa};
    tick(10);
    check_val("illegal_err", 64'(err_a), 64'd1);
    check_val("illegal_cnt", 64'(cnt_a), 64'(cnt_old));
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check_val("err_cleared", 64'(err_a), 64'd0);

    // Index homing at pos 57
    for (int i = 0; i < 40 && pos_a != 11'd57; i++) step(1'b1, 8);
    check_val("pre_index_pos", 64'(pos_a), 64'd57);
    cnt_old = cnt_a;
    qz = 1'b1;
    index_en = 1'b1;
    np = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (ipulse_a) np++;
    end
    check_val("index_pulses", 64'(np), 64'd1);
    check_val("index_pos", 64'(pos_a), 64'd0);
    check_val("index_cnt", 64'(cnt_a), 64'(cnt_old));
    qz = 1'b0;
    index_en = 1'b0;
    tick(10);

    // Fresh reset: x1 resolution, then velocity windows
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2 + FL);
    for (int i = 0; i < 4; i++) step(1'b1, 8);
    check_val("x1_cycle_cnt", 64'(cnt_b), 64'd1);
    check_val("x1_cycle_pos", 64'(pos_b), 64'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 8);
    check_val("x1_back_cnt", 64'(cnt_b), 64'd0);
    wait_vel_valid();
    for (int i = 0; i < 25; i++) step(1'b1, 8);
    wait_vel_valid();
    check_val("vel_25", 64'(vel_a), 64'd25);
    for (int i = 0; i < 64; i++) step(1'b1, 6);
    wait_vel_valid();
    check_val("vel_64", 64'(vel_a), 64'd64);
    check_val("vel_sat_pos", 64'(vel_b), 64'd7);
    for (int i = 0; i < 64; i++) step(1'b0, 6);
    wait_vel_valid();
    check_val("vel_neg64", 64'(vel_a), 64'h0000_0000_0000_ffc0);
    check_val("vel_sat_neg", 64'(vel_b), 64'd8);

    // Randomised traffic including glitches, illegal changes, index, clears and resets
    for (int i = 0; i < 400; i++) begin
      op   = int'($urandom_range(0, 11));
      hold = int'($urandom_range(1, 10));
      if (op <= 6) begin
        step(bit'($urandom_range(0, 1)), hold);
      end else if (op == 7) begin
        {qb, qa} = ~{qb, qa};
        tick(hold);
      end else if (op == 8) begin
        qz = ~qz;
        tick(hold);
      end else if (op == 9) begin
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(hold);
      end else if (op == 10) begin
        index_en = ~index_en;
        tick(hold);
      end else if ($urandom_range(0, 3) == 0) begin
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(hold);
      end else begin
        tick(hold);
      end
    end
    tick(20);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/quad_decoder_ext.md
Name: quad_decoder_ext

Overview:
- Next-generation incremental encoder front end for the Sensors group.
- Synchronises and glitch-filters the A/B/Z encoder inputs, then decodes quadrature at a selectable resolution (x4/x2/x1).
- Keeps a wrapping angular position and a signed running count, detects illegal transitions, homes on the index pulse, and reports velocity as signed counts per fixed window.
- Feeds the motor-control loop and speed telemetry.

Parameters:
- PPR, 334, encoder lines per revolution.
- MODE, 4, counts per line: 4, 2 or 1. Any other value is a synthesis error.
- FILT_LEN, 4, cycles (>=1) an input must hold a new level before it is accepted.
- CNT_W, 32, width of the signed running count.
- VEL_WIN, 100000, velocity window length in clk cycles (>=2).
- VEL_W, 16, width of the signed velocity output.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low: reset applies on a clk edge while rst=0.
- qa  in  1  encoder channel A, asynchronous.
- qb  in  1  encoder channel B, asynchronous.
- qz  in  1  encoder index, asynchronous.
- index_en  in  1  1 = filtered Z rising edge zeroes pos.
- err_clr  in  1  clears err.
- ready  out  1  high once initialisation is done.
- dir  out  1  direction of last counted step: 1 = forward (A leads B), 0 = reverse.
- pos  out  $clog2(PPR*MODE)  angular position, range 0..PPR*MODE-1.
- cnt  out  CNT_W  signed running step count, two's-complement wrap.
- err  out  1  sticky flag for an illegal transition (both A and B changed at once).
- index_pulse  out  1  one-cycle strobe on an accepted index homing.
- vel  out  VEL_W  signed step count of the last completed window.
- vel_valid  out  1  one-cycle strobe when vel updates.

Behaviour:
- Reset values: every output is 0. Synchroniser, filter and window registers are 0. FSM is in INIT.
- Synchroniser: 2 flip-flops per input (qa, qb, qz), giving synced value s.
- Filter, per input:
  - Holds filtered value f and a counter c.
  - c clears whenever s==f.
  - Otherwise c increments; when c==FILT_LEN-1 and s!=f still holds, f<=s and c<=0.
  - Pulses shorter than FILT_LEN cycles never reach f.
- FSM INIT:
  - Lasts 2+FILT_LEN cycles after reset release.
  - Filters load f<=s directly each cycle; the decoder's previous state p tracks {fb,fa}.
  - No steps, errors or index events.
  - Then moves to RUN and ready<=1.
- FSM RUN: each cycle compare n={fb,fa} against p, then p<=n.
  - Forward sequence 00->01->11->10->00; reverse is the opposite order.
  - Step qualification by MODE:
    - x4: every legal change counts.
    - x2: only changes of A count.
    - x1: forward counts only A rising; reverse counts only A falling.
  - Each counted step updates dir, cnt (+1/-1) and pos (+1/-1 modulo PPR*MODE), registered one cycle after f changes.
  - Any legal change that does not count leaves all outputs untouched.
  - Illegal change (n^p==11): err<=1, no count, p still updated.
  - err_clr=1 clears err. If an illegal change occurs in the same cycle, set wins.
- Latency: qa edge to pos update = 2 + FILT_LEN + 1 cycles.
- Index:
  - Filtered Z rising edge with index_en=1 in RUN sets pos<=0 and index_pulse=1 for one cycle.
  - It overrides a same-cycle step for pos only; cnt, dir and velocity still take the step.
- Velocity:
  - A window counter runs 0..VEL_WIN-1 in RUN.
  - The accumulator adds the signed step each cycle and saturates at -2^(VEL_W-1) and 2^(VEL_W-1)-1.
  - At count VEL_WIN-1: vel<=accumulator including that cycle's step, vel_valid=1, accumulator<=0, counter wraps.
  - Velocity is held at 0 in INIT.
- Wrap rules:
  - pos forward from PPR*MODE-1 goes to 0; reverse from 0 goes to PPR*MODE-1.
  - cnt wraps naturally.
- Reset mid-operation: any cycle with rst=0 returns everything to reset values and INIT, regardless of state.

Test Plan:
- Init: inputs held at qa=1, qb=1 through reset release -> ready rises after 2+FILT_LEN cycles, err=0, cnt=0, pos=0.
- x4 forward: 10 full forward Gray cycles (PPR=334, FILT_LEN=4) -> cnt=40, pos=40, dir=1. Each pos update occurs exactly 7 cycles after the qa/qb edge.
- Reverse wrap: one reverse step from pos=0 -> pos=1335, cnt=-1 (all ones), dir=0.
- Glitch filter and error:
  - A 3-cycle qa pulse with FILT_LEN=4 -> no count.
  - qa and qb toggled in the same cycle -> err=1 and cnt unchanged.
  - err_clr for 1 cycle -> err=0.
- MODE=1: one full forward cycle -> cnt=1, pos=1. One full reverse cycle -> cnt=0.
- Index and velocity (VEL_WIN=1000):
  - Index rising with index_en=1 at pos=57 -> pos=0, index_pulse for 1 cycle, cnt unchanged.
  - 25 forward steps within one window -> vel=25 with vel_valid pulsed once at the window end.
  - Excess steps with VEL_W=4 -> vel saturates at 7.
